// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction fetch and a data requester
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IReq_IN,
  input  logic [31:0] IAddr_IN,
  output logic [31:0] IData_OUT,
  output logic        IValid_OUT,
  input  logic        DReq_IN,
  input  logic        DWrite_IN,
  input  logic [31:0] DAddr_IN,
  input  logic [31:0] DWData_IN,
  input  logic [3:0]  DByteEn_IN,
  output logic [31:0] DRData_OUT,
  output logic        DValid_OUT,
  output logic        MemReq_OUT,
  output logic        MemWrite_OUT,
  output logic [31:0] MemAddr_OUT,
  output logic [31:0] MemWData_OUT,
  output logic [3:0]  MemByteEn_OUT,
  input  logic        MemReady_IN,
  input  logic [31:0] MemRData_IN,
  output logic        StallIF_OUT,
  output logic        StallMEM_OUT,
  output logic        Error_OUT
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, stateNext;
  logic [SW-1:0] starveCount;
  logic [CW-1:0] busyCount;
  logic bubble, grantI, grantD, done, timedOut, finish;
  // Arbitration and completion decode; a completion pulse cycle is a bubble with no grant
  always_comb begin
    bubble = IValid_OUT | DValid_OUT;
    grantD = state == IDLE && !bubble && DReq_IN && !(starveCount == SW'(STARVE_LIMIT) && IReq_IN);
    grantI = state == IDLE && !bubble && IReq_IN && !grantD;
    done = state != IDLE && MemReady_IN;
    timedOut = state != IDLE && !MemReady_IN && busyCount == CW'(TIMEOUT - 1);
    finish = done | timedOut;
    stateNext = grantD ? BUSY_D : grantI ? BUSY_I : finish ? IDLE : state;
    StallIF_OUT = RESET & IReq_IN & ~IValid_OUT;
    StallMEM_OUT = RESET & DReq_IN & ~DValid_OUT;
  end
  // State register, memory port launch, result capture, starvation and timeout tracking
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      starveCount <= '0;
      busyCount <= '0;
      IData_OUT <= '0;
      IValid_OUT <= 1'b0;
      DRData_OUT <= '0;
      DValid_OUT <= 1'b0;
      MemReq_OUT <= 1'b0;
      MemWrite_OUT <= 1'b0;
      MemAddr_OUT <= '0;
      MemWData_OUT <= '0;
      MemByteEn_OUT <= '0;
      Error_OUT <= 1'b0;
    end else begin
      state <= stateNext;
      IValid_OUT <= state == BUSY_I && finish;
      DValid_OUT <= state == BUSY_D && finish;
      if (state == BUSY_I && finish) IData_OUT <= done ? MemRData_IN : '0;
      if (state == BUSY_D && finish && !MemWrite_OUT) DRData_OUT <= done ? MemRData_IN : '0;
      if (grantI || grantD) begin
        MemReq_OUT <= 1'b1;
        MemWrite_OUT <= grantD & DWrite_IN;
        MemAddr_OUT <= grantD ? DAddr_IN : IAddr_IN;
        MemWData_OUT <= grantD ? DWData_IN : '0;
        MemByteEn_OUT <= grantD ? DByteEn_IN : 4'hF;
      end else if (finish) begin
        MemReq_OUT <= 1'b0;
        MemWrite_OUT <= 1'b0;
      end
      busyCount <= (grantI || grantD) ? '0 : state != IDLE ? busyCount + 1'b1 : busyCount;
      if (grantI) starveCount <= '0;
      else if (grantD && IReq_IN && starveCount != SW'(STARVE_LIMIT)) starveCount <= starveCount + 1'b1;
      Error_OUT <= Error_OUT | timedOut;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of the memory port arbiter
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  localparam int TO = 255;
  logic CLOCK = 1'b0, RESET = 1'b0;
  logic IReq_IN = 1'b0, DReq_IN = 1'b0, DWrite_IN = 1'b0, MemReady_IN = 1'b0;
  logic [31:0] IAddr_IN = '0, DAddr_IN = '0, DWData_IN = '0, MemRData_IN = '0;
  logic [3:0] DByteEn_IN = '0;
  logic [31:0] IData_OUT, DRData_OUT, MemAddr_OUT, MemWData_OUT;
  logic IValid_OUT, DValid_OUT, MemReq_OUT, MemWrite_OUT, StallIF_OUT, StallMEM_OUT, Error_OUT;
  logic [3:0] MemByteEn_OUT;
  int vectors = 0, miscompares = 0;
  logic [31:0] lastD;

  mem_port_arbiter #(.STARVE_LIMIT(LIM), .TIMEOUT(TO)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .IReq_IN(IReq_IN), .IAddr_IN(IAddr_IN), .IData_OUT(IData_OUT), .IValid_OUT(IValid_OUT),
    .DReq_IN(DReq_IN), .DWrite_IN(DWrite_IN), .DAddr_IN(DAddr_IN), .DWData_IN(DWData_IN),
    .DByteEn_IN(DByteEn_IN), .DRData_OUT(DRData_OUT), .DValid_OUT(DValid_OUT),
    .MemReq_OUT(MemReq_OUT), .MemWrite_OUT(MemWrite_OUT), .MemAddr_OUT(MemAddr_OUT),
    .MemWData_OUT(MemWData_OUT), .MemByteEn_OUT(MemByteEn_OUT), .MemReady_IN(MemReady_IN),
    .MemRData_IN(MemRData_IN), .StallIF_OUT(StallIF_OUT), .StallMEM_OUT(StallMEM_OUT),
    .Error_OUT(Error_OUT)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset;
    IReq_IN = 1; DReq_IN = 1; MemReady_IN = 1;
    #3;
    vectors++; if (MemReq_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_memreq got %b exp 0", MemReq_OUT); end
    vectors++; if (StallIF_OUT !== 1'b0 || StallMEM_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b%b exp 00", StallIF_OUT, StallMEM_OUT); end
    vectors++; if ({IValid_OUT, DValid_OUT, Error_OUT, MemWrite_OUT} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {IValid_OUT, DValid_OUT, Error_OUT, MemWrite_OUT}); end
    vectors++; if ({IData_OUT, DRData_OUT, MemAddr_OUT, MemByteEn_OUT} !== '0) begin miscompares++; $display("FAIL reset_data got %h exp 0", {IData_OUT, DRData_OUT, MemAddr_OUT}); end
    IReq_IN = 0; DReq_IN = 0; MemReady_IN = 0;
    tick;
    RESET = 1;
    tick;
    vectors++; if (MemReq_OUT !== 1'b0) begin miscompares++; $display("FAIL idle_no_req got %b exp 0", MemReq_OUT); end
  endtask

  task automatic test_fetch;
    IReq_IN = 1; IAddr_IN = 32'hBFC00000;
    tick;
    vectors++; if (MemReq_OUT !== 1'b1 || MemAddr_OUT !== 32'hBFC00000) begin miscompares++; $display("FAIL fetch_grant got %b %h exp 1 bfc00000", MemReq_OUT, MemAddr_OUT); end
    vectors++; if (MemByteEn_OUT !== 4'hF || MemWrite_OUT !== 1'b0) begin miscompares++; $display("FAIL fetch_be got %h %b exp f 0", MemByteEn_OUT, MemWrite_OUT); end
    vectors++; if (StallIF_OUT !== 1'b1) begin miscompares++; $display("FAIL fetch_stall got %b exp 1", StallIF_OUT); end
    tick;
    vectors++; if (MemReq_OUT !== 1'b1 || IValid_OUT !== 1'b0) begin miscompares++; $display("FAIL fetch_wait got %b %b exp 1 0", MemReq_OUT, IValid_OUT); end
    MemReady_IN = 1; MemRData_IN = 32'h3C1DA000;
    tick;
    MemReady_IN = 0;
    vectors++; if (IValid_OUT !== 1'b1 || IData_OUT !== 32'h3C1DA000) begin miscompares++; $display("FAIL fetch_done got %b %h exp 1 3c1da000", IValid_OUT, IData_OUT); end
    vectors++; if (MemReq_OUT !== 1'b0 || StallIF_OUT !== 1'b0) begin miscompares++; $display("FAIL fetch_release got %b %b exp 0 0", MemReq_OUT, StallIF_OUT); end
    IReq_IN = 0;
    tick;
    vectors++; if (IValid_OUT !== 1'b0 || IData_OUT !== 32'h3C1DA000) begin miscompares++; $display("FAIL fetch_pulse got %b %h exp 0 3c1da000", IValid_OUT, IData_OUT); end
  endtask

  task automatic test_together;
    IReq_IN = 1; IAddr_IN = 32'h00400000; DReq_IN = 1; DWrite_IN = 0; DAddr_IN = 32'h10008000; DByteEn_IN = 4'hF;
    tick;
    vectors++; if (MemAddr_OUT !== 32'h10008000 || MemReq_OUT !== 1'b1) begin miscompares++; $display("FAIL both_data_first got %h exp 10008000", MemAddr_OUT); end
    vectors++; if (StallIF_OUT !== 1'b1 || StallMEM_OUT !== 1'b1) begin miscompares++; $display("FAIL both_stalls got %b%b exp 11", StallIF_OUT, StallMEM_OUT); end
    MemReady_IN = 1; MemRData_IN = 32'h11223344;
    tick;
    MemReady_IN = 0;
    vectors++; if (DValid_OUT !== 1'b1 || DRData_OUT !== 32'h11223344 || StallMEM_OUT !== 1'b0) begin miscompares++; $display("FAIL both_load got %b %h exp 1 11223344", DValid_OUT, DRData_OUT); end
    DReq_IN = 0;
    tick;
    vectors++; if (MemReq_OUT !== 1'b0 || StallIF_OUT !== 1'b1) begin miscompares++; $display("FAIL both_bubble got %b %b exp 0 1", MemReq_OUT, StallIF_OUT); end
    tick;
    vectors++; if (MemReq_OUT !== 1'b1 || MemAddr_OUT !== 32'h00400000) begin miscompares++; $display("FAIL both_fetch got %b %h exp 1 00400000", MemReq_OUT, MemAddr_OUT); end
    MemReady_IN = 1; MemRData_IN = 32'h8FBF0014;
    tick;
    MemReady_IN = 0;
    vectors++; if (IValid_OUT !== 1'b1 || IData_OUT !== 32'h8FBF0014 || StallIF_OUT !== 1'b0) begin miscompares++; $display("FAIL both_fetch_done got %b %h %b exp 1 8fbf0014 0", IValid_OUT, IData_OUT, StallIF_OUT); end
    IReq_IN = 0;
    tick;
  endtask

  task automatic test_starve;
    int grants;
    bit prevReq, isI, expI;
    grants = 0; prevReq = 0;
    DReq_IN = 1; DWrite_IN = 0; DAddr_IN = 32'h100; IReq_IN = 1; IAddr_IN = 32'h200;
    MemReady_IN = 1; MemRData_IN = 32'hA5A50001;
    for (int c = 0; c < 80 && grants < 2 * (LIM + 1); c++) begin
      tick;
      if (MemReq_OUT && !prevReq) begin
        isI = MemAddr_OUT == 32'h200;
        expI = (grants + 1) % (LIM + 1) == 0;
        vectors++; if (isI !== expI) begin miscompares++; $display("FAIL starve_grant%0d got fetch=%b exp fetch=%b", grants, isI, expI); end
        grants++;
      end
      prevReq = MemReq_OUT;
    end
    vectors++; if (grants != 2 * (LIM + 1)) begin miscompares++; $display("FAIL starve_count got %0d exp %0d", grants, 2 * (LIM + 1)); end
    for (int c = 0; c < 10 && !IValid_OUT; c++) tick;
    IReq_IN = 0; DReq_IN = 0; MemReady_IN = 0;
    lastD = 32'hA5A50001;
    tick; tick;
  endtask

  task automatic test_store;
    DReq_IN = 1; DWrite_IN = 1; DAddr_IN = 32'h00000010; DWData_IN = 32'hDEADBEEF; DByteEn_IN = 4'b0011;
    tick;
    vectors++; if (MemWrite_OUT !== 1'b1 || MemByteEn_OUT !== 4'b0011) begin miscompares++; $display("FAIL store_strobe got %b %b exp 1 0011", MemWrite_OUT, MemByteEn_OUT); end
    vectors++; if (MemAddr_OUT !== 32'h10 || MemWData_OUT !== 32'hDEADBEEF) begin miscompares++; $display("FAIL store_port got %h %h exp 10 deadbeef", MemAddr_OUT, MemWData_OUT); end
    MemReady_IN = 1; MemRData_IN = 32'h55555555;
    tick;
    MemReady_IN = 0;
    vectors++; if (DValid_OUT !== 1'b1 || DRData_OUT !== lastD) begin miscompares++; $display("FAIL store_done got %b %h exp 1 %h", DValid_OUT, DRData_OUT, lastD); end
    DReq_IN = 0; DWrite_IN = 0;
    tick;
    vectors++; if (DValid_OUT !== 1'b0 || MemReq_OUT !== 1'b0) begin miscompares++; $display("FAIL store_pulse got %b %b exp 0 0", DValid_OUT, MemReq_OUT); end
  endtask

  task automatic test_random;
    int mOwner, mWait, mStarve;
    bit mIV, mDV, mWr, nIV, nDV, mReq;
    logic [31:0] mAddr, mWD, mID, mDD;
    logic [3:0] mBE;
    IReq_IN = 0; DReq_IN = 0; MemReady_IN = 0;
    RESET = 0;
    #3;
    RESET = 1;
    mOwner = 0; mWait = 0; mStarve = 0; mIV = 0; mDV = 0; mWr = 0;
    mAddr = '0; mWD = '0; mID = '0; mDD = '0; mBE = '0;
    for (int c = 0; c < 2000; c++) begin
      tick;
      mReq = mOwner != 0;
      vectors++; if (MemReq_OUT !== mReq) begin miscompares++; $display("FAIL rnd_memreq c%0d got %b exp %b", c, MemReq_OUT, mReq); end
      vectors++; if (IValid_OUT !== mIV || DValid_OUT !== mDV) begin miscompares++; $display("FAIL rnd_valid c%0d got %b%b exp %b%b", c, IValid_OUT, DValid_OUT, mIV, mDV); end
      vectors++; if (IData_OUT !== mID || DRData_OUT !== mDD) begin miscompares++; $display("FAIL rnd_rdata c%0d got %h %h exp %h %h", c, IData_OUT, DRData_OUT, mID, mDD); end
      vectors++; if (Error_OUT !== 1'b0) begin miscompares++; $display("FAIL rnd_error c%0d got %b exp 0", c, Error_OUT); end
      if (mReq) begin
        vectors++; if (MemAddr_OUT !== mAddr || MemByteEn_OUT !== mBE || MemWrite_OUT !== mWr) begin miscompares++; $display("FAIL rnd_port c%0d got %h %h %b exp %h %h %b", c, MemAddr_OUT, MemByteEn_OUT, MemWrite_OUT, mAddr, mBE, mWr); end
        if (mWr) begin
          vectors++; if (MemWData_OUT !== mWD) begin miscompares++; $display("FAIL rnd_wdata c%0d got %h exp %h", c, MemWData_OUT, mWD); end
        end
      end
      if (IReq_IN) begin
        if (mIV && $urandom_range(0, 1) == 1) IReq_IN = 0;
        else if (mIV) IAddr_IN = $urandom;
      end else if ($urandom_range(0, 2) == 0) begin
        IReq_IN = 1; IAddr_IN = $urandom;
      end
      if (DReq_IN) begin
        if (mDV && $urandom_range(0, 1) == 1) DReq_IN = 0;
        else if (mDV) begin DAddr_IN = $urandom; DWData_IN = $urandom; DWrite_IN = 1'($urandom); DByteEn_IN = 4'($urandom); end
      end else if ($urandom_range(0, 2) == 0) begin
        DReq_IN = 1; DAddr_IN = $urandom; DWData_IN = $urandom; DWrite_IN = 1'($urandom); DByteEn_IN = 4'($urandom);
      end
      MemReady_IN = mReq ? $urandom_range(0, 2) == 0 : $urandom_range(0, 3) == 0;
      MemRData_IN = $urandom;
      #1;
      vectors++; if (StallIF_OUT !== (IReq_IN & !mIV) || StallMEM_OUT !== (DReq_IN & !mDV)) begin miscompares++; $display("FAIL rnd_stall c%0d got %b%b exp %b%b", c, StallIF_OUT, StallMEM_OUT, IReq_IN & !mIV, DReq_IN & !mDV); end
      nIV = 0; nDV = 0;
      if (mOwner == 0) begin
        if (!mIV && !mDV) begin
          if (DReq_IN && !(mStarve == LIM && IReq_IN)) begin
            mOwner = 2; mWait = 0; mAddr = DAddr_IN; mBE = DByteEn_IN; mWr = DWrite_IN; mWD = DWData_IN;
            if (IReq_IN && mStarve < LIM) mStarve++;
          end else if (IReq_IN) begin
            mOwner = 1; mWait = 0; mAddr = IAddr_IN; mBE = 4'hF; mWr = 0; mStarve = 0;
          end
        end
      end else begin
        mWait++;
        if (MemReady_IN || mWait == TO) begin
          if (mOwner == 1) begin nIV = 1; mID = MemReady_IN ? MemRData_IN : '0; end
          else begin nDV = 1; if (!mWr) mDD = MemReady_IN ? MemRData_IN : '0; end
          mOwner = 0; mWr = 0;
        end
      end
      mIV = nIV; mDV = nDV;
    end
    IReq_IN = 0; DReq_IN = 0; MemReady_IN = 1;
    repeat (4) tick;
    MemReady_IN = 0;
    tick;
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    DReq_IN = 1; DWrite_IN = 0; DAddr_IN = 32'h40;
    tick;
    while (MemReq_OUT && n < 300) begin n++; tick; end
    vectors++; if (n != TO) begin miscompares++; $display("FAIL timeout_cycles got %0d exp %0d", n, TO); end
    vectors++; if (DValid_OUT !== 1'b1 || DRData_OUT !== 32'h0) begin miscompares++; $display("FAIL timeout_pulse got %b %h exp 1 0", DValid_OUT, DRData_OUT); end
    vectors++; if (Error_OUT !== 1'b1 || MemReq_OUT !== 1'b0) begin miscompares++; $display("FAIL timeout_error got %b %b exp 1 0", Error_OUT, MemReq_OUT); end
    DReq_IN = 0;
    repeat (5) tick;
    vectors++; if (Error_OUT !== 1'b1 || DValid_OUT !== 1'b0) begin miscompares++; $display("FAIL timeout_sticky got %b %b exp 1 0", Error_OUT, DValid_OUT); end
  endtask

  task automatic test_reset_mid;
    DReq_IN = 1; DWrite_IN = 1; DAddr_IN = 32'h80; DWData_IN = 32'h1; DByteEn_IN = 4'hF;
    tick;
    vectors++; if (MemReq_OUT !== 1'b1) begin miscompares++; $display("FAIL mid_grant got %b exp 1", MemReq_OUT); end
    IReq_IN = 1; IAddr_IN = 32'h300;
    #2;
    RESET = 0;
    #1;
    vectors++; if (MemReq_OUT !== 1'b0 || MemWrite_OUT !== 1'b0 || Error_OUT !== 1'b0) begin miscompares++; $display("FAIL mid_async got %b %b %b exp 0 0 0", MemReq_OUT, MemWrite_OUT, Error_OUT); end
    vectors++; if (MemAddr_OUT !== 32'h0 || StallIF_OUT !== 1'b0) begin miscompares++; $display("FAIL mid_clear got %h %b exp 0 0", MemAddr_OUT, StallIF_OUT); end
    DReq_IN = 0;
    #1;
    RESET = 1;
    tick;
    vectors++; if (MemReq_OUT !== 1'b1 || MemAddr_OUT !== 32'h300 || MemByteEn_OUT !== 4'hF) begin miscompares++; $display("FAIL mid_regrant got %b %h %h exp 1 300 f", MemReq_OUT, MemAddr_OUT, MemByteEn_OUT); end
    MemReady_IN = 1; MemRData_IN = 32'hCAFEF00D;
    tick;
    MemReady_IN = 0;
    vectors++; if (IValid_OUT !== 1'b1 || IData_OUT !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mid_fetch got %b %h exp 1 cafef00d", IValid_OUT, IData_OUT); end
    IReq_IN = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_together;
    test_starve;
    test_store;
    test_random;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
